// File: rtl/add_imm.sv
`default_nettype none
// ============================================================================
//  Module      : add_imm
//  Description : Registered address adder. It produces a branch or jump
//                target as base address plus an immediate that has been
//                shifted left by IMM_SHIFT bits. Arithmetic wraps modulo
//                2^WIDTH, and there is no carry-out.
//
//  Parameters  : WIDTH     - width of the address and immediate vectors
//                IMM_SHIFT - left shift applied to the immediate (0..3)
//
//  Ports       : i_Clk        - clock; state changes on the rising edge
//                i_Rst        - asynchronous active-high reset; clears output
//                i_Enb        - 1 captures a new sum, 0 holds the output
//                iv_Dir       - base address (current PC)
//                iv_imm       - immediate offset, two's complement
//                ov_Dir_shift - registered target address
//
//  Revision    : 1.0 - initial release
// ============================================================================
module add_imm #(
    parameter int WIDTH     = 32,
    parameter int IMM_SHIFT = 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Enb,
    input  logic [WIDTH-1:0] iv_Dir,
    input  logic [WIDTH-1:0] iv_imm,
    output logic [WIDTH-1:0] ov_Dir_shift
);

    localparam logic [WIDTH-1:0] c_RST_VAL = '0;

    logic [WIDTH-1:0] w_imm_shifted;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_dir_shift;

    // The shift is logical and is truncated to WIDTH bits, so offset MSBs are
    // discarded. Two's-complement addition makes signed and unsigned offsets
    // produce the same bits, and negative immediates act as backward offsets.
    assign w_imm_shifted = iv_imm << IMM_SHIFT;
    assign w_sum         = iv_Dir + w_imm_shifted;

    // This is the only state element. Reset takes priority over enable.
    // Because the output always comes from this register, it is safe to feed
    // it back into either adder input.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_dir_shift <= c_RST_VAL;
        end else if (i_Enb) begin
            r_dir_shift <= w_sum;
        end
    end

    assign ov_Dir_shift = r_dir_shift;

endmodule
`default_nettype wire

// File: tb/tb_add_imm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_imm
//  Description : Self-checking bench for add_imm. Each expected output comes
//                from a plain-arithmetic reference model of the target-address
//                rule. Directed scenarios run first, followed by a randomized
//                run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_imm;

    localparam int WIDTH     = 32;
    localparam int IMM_SHIFT = 1;

    logic             clk;
    logic             rst;
    logic             enb;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] dir_shift;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state: the value the output register is expected to hold.
    logic [WIDTH-1:0] exp_q;

    add_imm #(
        .WIDTH     (WIDTH),
        .IMM_SHIFT (IMM_SHIFT)
    ) u_dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Enb        (enb),
        .iv_Dir       (dir),
        .iv_imm       (imm),
        .ov_Dir_shift (dir_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target = base + imm * 2^shift, reduced modulo 2^32.
    function automatic logic [WIDTH-1:0] ref_target(input logic [WIDTH-1:0] b,
                                                    input logic [WIDTH-1:0] o);
        longint unsigned t;
        t = longint'(b) + longint'(o) * (longint'(1) << IMM_SHIFT);
        return WIDTH'(t % (longint'(1) << WIDTH));
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] expv);
        n_total++;
        assert (dir_shift === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, dir_shift, expv);
        end
    endtask

    // Advance one rising edge, update the model, and sample 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst)      exp_q = '0;
        else if (enb) exp_q = ref_target(dir, imm);
        #1;
        check(tag, exp_q);
    endtask

    initial begin
        exp_q = '0;
        // Reset held, with an immediate that would otherwise give FFFFFFFE.
        rst = 1'b1; enb = 1'b1; dir = '0; imm = 32'hFFFF_FFFF;
        #1;
        check("reset_before_edge", 32'h0);
        tick("reset_edge1");
        tick("reset_edge2");

        // Release reset between edges; the first enabled edge captures.
        rst = 1'b0;
        tick("first_capture");
        check("first_capture_const", 32'hFFFF_FFFE);

        // Feedback chain: the immediate is driven from the output.
        for (int i = 0; i < 9; i++) begin
            dir = '0;
            imm = dir_shift;
            @(posedge clk);
            exp_q = ref_target(32'h0, exp_q);
            #1;
            check("feedback", exp_q);
        end
        check("feedback_end_const", 32'hFFFF_FC00);

        // Basic add, forward offset and backward offset.
        dir = 32'h0000_1000; imm = 32'h0000_0010;
        tick("add_fwd");
        check("add_fwd_const", 32'h0000_1020);

        // Enable hold: inputs change while enable is low, output must not.
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dir = $urandom; imm = $urandom;
            tick("hold");
        end
        check("hold_const", 32'h0000_1020);
        enb = 1'b1;
        dir = 32'h0000_1000; imm = 32'hFFFF_FFF8;
        tick("add_back");
        check("add_back_const", 32'h0000_0FF0);

        // Wrap-around and discarded MSB.
        dir = 32'hFFFF_FFFC; imm = 32'h0000_0002;
        tick("wrap");
        check("wrap_const", 32'h0000_0000);
        dir = 32'h0; imm = 32'h8000_0001;
        tick("msb_out");
        check("msb_out_const", 32'h0000_0002);

        // Input changes between edges must not reach the output.
        dir = 32'h1234_5678; imm = 32'h0000_0100;
        #1;
        check("no_comb_path", exp_q);
        tick("post_change");

        // Asynchronous reset between edges while the output is nonzero.
        #2;
        rst = 1'b1;
        exp_q = '0;
        #1;
        check("async_reset_immediate", 32'h0);
        tick("reset_held_enb1");
        tick("reset_held_enb1_b");
        rst = 1'b0;
        dir = 32'h0000_2000; imm = 32'h0000_0004;
        tick("resume_after_reset");
        check("resume_const", 32'h0000_2008);

        // Randomized run against the model.
        for (int i = 0; i < 60; i++) begin
            enb = ($urandom_range(0, 3) != 0);
            dir = $urandom;
            imm = $urandom;
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
